// File: rtl/spi_master_pkg.sv
// Shared types and constants for the memory-mapped SPI initiator.
package spi_master_pkg;

    // Transfer sequencing: chip-select setup, 64 SCK half-periods, chip-select hold.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // Word offsets on the data bus (DataAdrM[3:2]).
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions.
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_OVERRUN = 2;

    // A 32-bit word needs 64 SCK half-periods; the counter runs 0..63.
    localparam logic [5:0] LAST_HALF = 6'd63;

    // Assemble the STATUS read word from its flags.
    function automatic logic [31:0] status_word(input logic busy,
                                                input logic done,
                                                input logic overrun);
        logic [31:0] w;
        w                 = '0;
        w[STATUS_BUSY]    = busy;
        w[STATUS_DONE]    = done;
        w[STATUS_OVERRUN] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// Half-period tick generator. The count is held at zero while disabled, so
// every transfer starts with a full half-period after enable rises.
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Count 0..div while enabled; wrap on reaching div, hold zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == div);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator on the core data bus. Writing TXDATA launches a
// 32-bit full-duplex transfer; STATUS reports busy/done/overrun; RXDATA
// holds the word captured by the most recent completed transfer.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int               DIV_W       = 8,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 8'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        SPI_CLK,
    output logic        SPI_CS_N,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        done_irq,
    output spi_state_t  dbg_state
);

    // Sequencer state and its next-state values.
    spi_state_t state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  hc_q, hc_d;
    logic        sclk_q, sclk_d;
    logic        csn_q, csn_d;
    logic        mosi_q, mosi_d;
    logic        rise;
    logic        rx_load;

    // Receive path: synchronizer, delayed capture strobe, receive word.
    logic        miso_s1, miso_s2;
    logic        rise_p1, rise_p2;
    logic [31:0] rx_sr;

    // Software-visible registers.
    logic [31:0]      txdata_q;
    logic [31:0]      rxdata_q;
    logic             done_q;
    logic             ovr_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_lat;

    logic busy;
    logic tick;
    logic wr_tx, wr_status, wr_ctrl;
    logic tx_start, tx_overrun;

    assign busy       = (state_q != IDLE);
    assign wr_tx      = cs && we && (addr == REG_TXDATA);
    assign wr_status  = cs && we && (addr == REG_STATUS);
    assign wr_ctrl    = cs && we && (addr == REG_CTRL);
    assign tx_start   = wr_tx && !busy;
    assign tx_overrun = wr_tx && busy;

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (busy),
        .div     (div_lat),
        .tick    (tick)
    );

    // Next-state and next-pin values; every pin is registered below.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        hc_d    = hc_q;
        sclk_d  = sclk_q;
        csn_d   = csn_q;
        mosi_d  = mosi_q;
        rise    = 1'b0;
        rx_load = 1'b0;
        case (state_q)
            IDLE: begin
                csn_d  = 1'b1;
                sclk_d = 1'b0;
                if (tx_start) begin
                    sr_d    = wdata;
                    mosi_d  = wdata[31];
                    csn_d   = 1'b0;
                    hc_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // End of setup half-period is the first rising SCK edge.
                if (tick) begin
                    sclk_d  = 1'b1;
                    rise    = 1'b1;
                    hc_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (hc_q == LAST_HALF) begin
                        state_d = HOLD;
                    end else begin
                        hc_d = hc_q + 6'd1;
                        if (!hc_q[0]) begin
                            // High half ends: falling edge, present next bit.
                            sclk_d = 1'b0;
                            sr_d   = {sr_q[30:0], 1'b0};
                            mosi_d = sr_q[30];
                        end else begin
                            // Low half ends: rising edge, device data sampled.
                            sclk_d = 1'b1;
                            rise   = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    rx_load = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, shift register, half-period counter and SPI pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            hc_q    <= '0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            hc_q    <= hc_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            mosi_q  <= mosi_d;
        end
    end

    // MISO passes two flops; the capture strobe is delayed by the same two
    // cycles so the bit taken is the pin level at the rising SCK edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
            rise_p1 <= 1'b0;
            rise_p2 <= 1'b0;
            rx_sr   <= '0;
        end else begin
            miso_s1 <= SPI_MISO;
            miso_s2 <= miso_s1;
            rise_p1 <= rise;
            rise_p2 <= rise_p1;
            if (tx_start) begin
                rx_sr <= '0;
            end else if (rise_p2) begin
                rx_sr <= {rx_sr[30:0], miso_s2};
            end
        end
    end

    // Bus registers; done set at end of HOLD beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txdata_q <= '0;
            rxdata_q <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            div_q    <= DEFAULT_DIV;
            div_lat  <= DEFAULT_DIV;
        end else begin
            if (wr_tx) begin
                txdata_q <= wdata;
            end
            if (wr_ctrl) begin
                div_q <= wdata[DIV_W-1:0];
            end
            if (tx_start) begin
                div_lat <= div_q;
            end
            if (rx_load) begin
                rxdata_q <= rx_sr;
            end
            if (rx_load) begin
                done_q <= 1'b1;
            end else if (tx_start) begin
                done_q <= 1'b0;
            end else if (wr_status && wdata[STATUS_DONE]) begin
                done_q <= 1'b0;
            end
            if (tx_overrun) begin
                ovr_q <= 1'b1;
            end else if (wr_status && wdata[STATUS_OVERRUN]) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Read mux, decoded from addr alone so reads need no select.
    always_comb begin
        rdata = '0;
        case (addr)
            REG_TXDATA: rdata = txdata_q;
            REG_RXDATA: rdata = rxdata_q;
            REG_STATUS: rdata = status_word(busy, done_q, ovr_q);
            REG_CTRL:   rdata = {{(32-DIV_W){1'b0}}, div_q};
            default:    rdata = '0;
        endcase
    end

    assign SPI_CLK   = sclk_q;
    assign SPI_CS_N  = csn_q;
    assign SPI_MOSI  = mosi_q;
    assign done_irq  = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed boundary cases plus random
// transfers, compared against a register-level model and an expected queue.
module tb_spi_master;

  localparam logic [1:0] A_TX   = 2'd0;
  localparam logic [1:0] A_RX   = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        SPI_CLK, SPI_CS_N, SPI_MOSI, SPI_MISO, done_irq;
  logic [1:0]  dbg_state;

  // bench-side SPI device: loopback or a word shifted out MSB first
  bit          loop_mode = 1'b1;
  logic [31:0] slave_word = '0;
  logic        slave_bit = 1'b0;
  int          slave_idx = 0;
  assign SPI_MISO = loop_mode ? SPI_MOSI : slave_bit;

  always @(negedge SPI_CS_N) begin
    slave_bit = slave_word[31];
    slave_idx = 30;
  end

  always @(negedge SPI_CLK) begin
    if (!SPI_CS_N && slave_idx >= 0) begin
      slave_bit = slave_word[slave_idx];
      slave_idx = slave_idx - 1;
    end
  end

  spi_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .SPI_CLK   (SPI_CLK),
    .SPI_CS_N  (SPI_CS_N),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO),
    .done_irq  (done_irq),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // reference model of the register file
  int   m_div = 4;
  logic [31:0] m_rx = '0;
  logic m_done = 1'b0;
  logic m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: callers sit at a falling clk edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1;
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    cs = 1'b0;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic set_div(input int v);
    bus_write(A_CTRL, v);
    m_div = v;
  endtask

  // One transfer. mid_kind: 0 none, 1 TXDATA write, 2 CTRL write, 3 STATUS
  // write, issued in busy cycle mid_at. abort_edges>0 pulls reset after
  // that many SCK edges.
  task automatic do_xfer(input logic [31:0] tx, input bit lp, input logic [31:0] sw,
                         input int mid_at, input int mid_kind, input logic [31:0] mid_val,
                         input int abort_edges);
    int dv, budget, cyc, rises, edges, run, mosi_bad;
    logic [31:0] got, rd;
    logic last_mosi, prev_sck;
    bit aborted;
    dv = m_div;
    budget = 66 * (dv + 1) + 40;
    loop_mode = lp;
    slave_word = sw;
    exp_q.push_back(lp ? tx : sw);
    m_done = 1'b0;
    bus_write(A_TX, tx);
    cyc = 0; rises = 0; edges = 0; run = 0; mosi_bad = 0;
    got = '0; prev_sck = 1'b0; last_mosi = SPI_MOSI; aborted = 1'b0;
    while (SPI_CS_N == 1'b0 && cyc < budget) begin
      cyc++;
      if (SPI_MOSI === last_mosi) run++;
      else begin
        run = 1;
        last_mosi = SPI_MOSI;
      end
      if (SPI_CLK !== prev_sck) edges++;
      if (SPI_CLK === 1'b1 && prev_sck === 1'b0) begin
        rises++;
        got = {got[30:0], SPI_MOSI};
        if (run - 1 < dv + 1) mosi_bad++;
      end
      prev_sck = SPI_CLK;
      if (cyc == 1) begin
        bus_read(A_STAT, rd);
        check("status_busy", rd, {29'd0, m_ovr, 1'b0, 1'b1});
      end
      cs = 1'b0;
      we = 1'b0;
      if (mid_kind != 0 && cyc == mid_at) begin
        cs = 1'b1;
        we = 1'b1;
        wdata = mid_val;
        if (mid_kind == 1) begin
          addr = A_TX;
          m_ovr = 1'b1;
        end else if (mid_kind == 2) begin
          addr = A_CTRL;
          m_div = int'(mid_val[7:0]);
        end else begin
          addr = A_STAT;
          if (mid_val[2]) m_ovr = 1'b0;
        end
      end
      if (abort_edges > 0 && edges >= abort_edges) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cs = 1'b0;
    we = 1'b0;
    if (aborted) begin
      reset_n = 1'b0;
      #1;
      check("abort_sck", SPI_CLK, 0);
      check("abort_csn", SPI_CS_N, 1);
      check("abort_mosi", SPI_MOSI, 0);
      check("abort_irq", done_irq, 0);
      void'(exp_q.pop_back());
      @(negedge clk);
      reset_n = 1'b1;
      m_div = 4; m_rx = '0; m_done = 1'b0; m_ovr = 1'b0;
      bus_read(A_RX, rd);
      check("abort_rx", rd, m_rx);
      bus_read(A_STAT, rd);
      check("abort_status", rd, 32'd0);
      bus_read(A_CTRL, rd);
      check("abort_ctrl", rd, 32'd4);
      return;
    end
    check("busy_cycles", cyc, 66 * (dv + 1));
    check("sck_rises", rises, 32);
    check("mosi_msb_first", got, tx);
    check("mosi_stable", mosi_bad, 0);
    m_rx = exp_q.pop_front();
    m_done = 1'b1;
    bus_read(A_RX, rd);
    check("rxdata", rd, m_rx);
    bus_read(A_STAT, rd);
    check("status_end", rd, {29'd0, m_ovr, m_done, 1'b0});
    check("done_irq", done_irq, 1);
  endtask

  initial begin
    logic [31:0] rd;
    int dv;
    bit lp;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset state
    check("rst_sck", SPI_CLK, 0);
    check("rst_csn", SPI_CS_N, 1);
    check("rst_mosi", SPI_MOSI, 0);
    check("rst_irq", done_irq, 0);
    bus_read(A_TX, rd);   check("rst_tx", rd, 32'd0);
    bus_read(A_RX, rd);   check("rst_rx", rd, 32'd0);
    bus_read(A_STAT, rd); check("rst_status", rd, 32'd0);
    bus_read(A_CTRL, rd); check("rst_ctrl", rd, 32'd4);

    // div=0 loopback
    set_div(0);
    do_xfer(32'hA5A5_0F0F, 1'b1, 32'd0, 0, 0, 32'd0, 0);
    bus_read(A_TX, rd);
    check("tx_readback", rd, 32'hA5A5_0F0F);

    // div=3 device word, back-to-back with previous completion
    set_div(3);
    do_xfer($urandom, 1'b0, 32'h1234_5678, 0, 0, 32'd0, 0);

    // STATUS clear of done in the very cycle done is set: set wins
    do_xfer($urandom, 1'b0, $urandom, 66 * 4, 3, 32'h2, 0);

    // overrun: TXDATA write mid-transfer leaves the running word alone
    set_div(2);
    do_xfer(32'h3C5A_96E1, 1'b1, 32'd0, 40, 1, 32'hFFFF_FFFF, 0);
    bus_write(A_STAT, 32'h6);
    m_done = 1'b0;
    m_ovr = 1'b0;
    bus_read(A_STAT, rd);
    check("w1c_status", rd, 32'd0);
    check("w1c_irq", done_irq, 0);

    // CTRL write during a div=1 transfer applies only to the next one
    set_div(1);
    do_xfer($urandom, 1'b1, 32'd0, 30, 2, 32'd7, 0);
    bus_read(A_CTRL, rd);
    check("ctrl_updated", rd, 32'd7);
    do_xfer($urandom, 1'b0, $urandom, 0, 0, 32'd0, 0);

    // all-ones divider
    set_div(255);
    do_xfer($urandom, 1'b0, $urandom, 0, 0, 32'd0, 0);

    // random transfers
    for (int i = 0; i < 6; i++) begin
      dv = $urandom_range(0, 5);
      set_div(dv);
      lp = (dv == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      do_xfer($urandom, lp, $urandom, 0, 0, 32'd0, 0);
    end

    // reset mid-transfer, then recovery at the default divider
    set_div(2);
    do_xfer($urandom, 1'b1, 32'd0, 0, 0, 32'd0, 20);
    do_xfer($urandom, 1'b0, $urandom, 0, 0, 32'd0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
